mem_stage_pipe: RTL and testbench

- Parametrised memory/writeback stage for the NaiveMIPS core.
- Takes E-stage memory and ALU results and issues loads and stores on an SRAM-like data bus with a req/addr_ok/data_ok handshake.
- Applies MIPS load extension and LWL/LWR merge, then carries results through STAGES result registers to register-file write.
- Adds behaviour the older stage lacks: configurable result depth, a drain state for bus transactions in flight when an exception flush arrives, and multi-stage store-data forwarding.

---
 rtl/mem_stage_pipe.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_mem_stage_pipe.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_pipe.sv
// NaiveMIPS memory/writeback stage.
// Issues loads/stores on an SRAM-like req/addr_ok/data_ok bus, applies load
// extension and LWL/LWR merge, and carries results through STAGES registers.
// Optional build macro: MEM_ALIGN_EXC_EN (raise adel/ades instead of masking
// misaligned addresses).
module mem_stage_pipe #(
    parameter int STAGES = 1,
    parameter int T_W    = 4,
    parameter int PC_W   = 32
) (
    input  logic            Clk,
    input  logic            Clr,
    input  logic            exp_flush,
    input  logic            e_valid,
    input  logic [PC_W-1:0] e_pc,
    input  logic [31:0]     e_data,
    input  logic            e_mem,
    input  logic [3:0]      e_ls_type,
    input  logic [4:0]      e_rt_id,
    input  logic [31:0]     e_rt_value,
    input  logic            e_wreg_en,
    input  logic [4:0]      e_reg_id,
    input  logic [T_W-1:0]  e_t,
    output logic            stall,
    output logic            req,
    output logic            wr,
    output logic [1:0]      size,
    output logic [31:0]     addr,
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    input  logic            addr_ok,
    input  logic            data_ok,
    input  logic [31:0]     rdata,
    output logic            m_wreg_en,
    output logic [3:0]      m_reg_be,
    output logic [4:0]      m_reg_id,
    output logic [31:0]     m_data,
    output logic [PC_W-1:0] m_pc,
    output logic [T_W-1:0]  m_t
`ifdef MEM_ALIGN_EXC_EN
    ,
    output logic            adel,
    output logic            ades,
    output logic [31:0]     badvaddr
`endif
);

    localparam logic [3:0] LS_LB  = 4'd0,  LS_LBU = 4'd1,  LS_LH  = 4'd2,
                           LS_LHU = 4'd3,  LS_LW  = 4'd4,  LS_LWL = 4'd5,
                           LS_LWR = 4'd6,  LS_SB  = 4'd8,  LS_SH  = 4'd9,
                           LS_SW  = 4'd10, LS_SWL = 4'd11, LS_SWR = 4'd12;

    typedef enum logic [1:0] {IDLE, WAIT_ADDR, WAIT_DATA, DRAIN} state_t;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bus_req_t;

    typedef struct packed {
        logic [3:0]      ls_type;
        logic [1:0]      off;
        logic            wreg_en;
        logic [4:0]      reg_id;
        logic [PC_W-1:0] pc;
        logic [T_W-1:0]  t;
    } op_t;

    typedef struct packed {
        logic            wreg_en;
        logic [3:0]      be;
        logic [4:0]      reg_id;
        logic [31:0]     data;
        logic [PC_W-1:0] pc;
        logic [T_W-1:0]  t;
    } stage_t;

    function automatic logic [T_W-1:0] t_dec(input logic [T_W-1:0] t);
        return (t == '0) ? '0 : t - T_W'(1);
    endfunction

    // {byte enables, data} for a load result
    function automatic logic [35:0] ld_ext(input logic [3:0] ty, input logic [1:0] off,
                                           input logic [31:0] rd);
        logic [31:0] lane;
        logic [1:0]  noff;
        lane = rd >> {off, 3'b000};
        noff = 2'd3 - off;
        case (ty)
            LS_LB:   return {4'hF, {24{lane[7]}}, lane[7:0]};
            LS_LBU:  return {4'hF, 24'h0, lane[7:0]};
            LS_LH:   return {4'hF, {16{lane[15]}}, lane[15:0]};
            LS_LHU:  return {4'hF, 16'h0, lane[15:0]};
            LS_LWL:  return {4'hF << noff, rd << {noff, 3'b000}};
            LS_LWR:  return {4'hF >> off, rd >> {off, 3'b000}};
            default: return {4'hF, rd};
        endcase
    endfunction

    state_t      state;
    bus_req_t    ereq, pend_req, cur_req;
    op_t         e_op, pend_op, cur_op;
    stage_t      stg [1:STAGES];
    stage_t      s1_d;
    logic [31:0] rt_fwd;
    logic [1:0]  e_off;
    logic        is_ld, is_st, mem_op, mis, issue, complete;
    logic [35:0] ld_res;

    // classify the E op
    always_comb begin
        is_ld  = (e_ls_type <= LS_LWR);
        is_st  = (e_ls_type >= LS_SB) && (e_ls_type <= LS_SWR);
        mem_op = e_valid && e_mem && (is_ld || is_st);
`ifdef MEM_ALIGN_EXC_EN
        mis = mem_op &&
              ((((e_ls_type == LS_LH) || (e_ls_type == LS_LHU) || (e_ls_type == LS_SH)) && e_data[0]) ||
               (((e_ls_type == LS_LW) || (e_ls_type == LS_SW)) && (e_data[1:0] != 2'b00)));
`else
        mis = 1'b0;
`endif
    end

`ifdef MEM_ALIGN_EXC_EN
    assign adel     = mis && is_ld && !exp_flush;
    assign ades     = mis && is_st && !exp_flush;
    assign badvaddr = e_data;
`endif

    // store data comes from the youngest in-flight writer of rt; stage 1 wins
    always_comb begin
        rt_fwd = e_rt_value;
        for (int k = STAGES; k >= 1; k--) begin
            if (stg[k].wreg_en && (stg[k].reg_id == e_rt_id) && (e_rt_id != 5'd0))
                rt_fwd = stg[k].data;
        end
    end

    // bus request fields derived from the E op; low bits masked to natural alignment
    always_comb begin
        ereq    = '0;
        e_off   = e_data[1:0];
        ereq.wr = is_st;
        case (e_ls_type)
            LS_LH, LS_LHU, LS_SH: begin
                ereq.size = 2'd1;
                e_off     = {e_data[1], 1'b0};
            end
            LS_LW, LS_SW: begin
                ereq.size = 2'd2;
                e_off     = 2'd0;
            end
            LS_LWL, LS_LWR, LS_SWL, LS_SWR: ereq.size = 2'd2;
            default: ereq.size = 2'd0;
        endcase
        case (ereq.size)
            2'd1:    ereq.addr = {e_data[31:1], 1'b0};
            2'd2:    ereq.addr = {e_data[31:2], 2'b00};
            default: ereq.addr = e_data;
        endcase
        case (e_ls_type)
            LS_SB: begin
                ereq.wdata = rt_fwd << {e_off, 3'b000};
                ereq.wstrb = 4'h1 << e_off;
            end
            LS_SH: begin
                ereq.wdata = rt_fwd << {e_off, 3'b000};
                ereq.wstrb = 4'h3 << e_off;
            end
            LS_SW: begin
                ereq.wdata = rt_fwd;
                ereq.wstrb = 4'hF;
            end
            LS_SWL: begin
                ereq.wdata = rt_fwd >> {2'd3 - e_off, 3'b000};
                ereq.wstrb = 4'hF >> (2'd3 - e_off);
            end
            LS_SWR: begin
                ereq.wdata = rt_fwd << {e_off, 3'b000};
                ereq.wstrb = 4'hF << e_off;
            end
            default: begin
                ereq.wdata = 32'h0;
                ereq.wstrb = 4'h0;
            end
        endcase
        e_op = '{ls_type: e_ls_type, off: e_off, wreg_en: e_wreg_en,
                 reg_id: e_reg_id, pc: e_pc, t: e_t};
    end

    // handshake: live E fields in IDLE, latched fields while a transaction is open
    always_comb begin
        cur_req  = (state == IDLE) ? ereq : pend_req;
        cur_op   = (state == IDLE) ? e_op : pend_op;
        issue    = (state == IDLE) && mem_op && !exp_flush && !mis;
        req      = issue || ((state == WAIT_ADDR) && !exp_flush);
        complete = (issue && addr_ok && data_ok) ||
                   ((state == WAIT_ADDR) && !exp_flush && addr_ok && data_ok) ||
                   ((state == WAIT_DATA) && !exp_flush && data_ok);
        stall    = (mem_op && !exp_flush && !mis && !complete) ||
                   ((state == DRAIN) && mem_op && !mis);
        wr       = cur_req.wr;
        size     = cur_req.size;
        addr     = cur_req.addr;
        wdata    = cur_req.wdata;
        wstrb    = cur_req.wstrb;
    end

    // bus state machine; latches the request so it stays stable across waits
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state    <= IDLE;
            pend_req <= '0;
            pend_op  <= '0;
        end else begin
            case (state)
                IDLE: if (issue) begin
                    pend_req <= ereq;
                    pend_op  <= e_op;
                    if (addr_ok && data_ok) state <= IDLE;
                    else if (addr_ok)       state <= WAIT_DATA;
                    else                    state <= WAIT_ADDR;
                end
                WAIT_ADDR: begin
                    if (exp_flush)    state <= IDLE;
                    else if (addr_ok) state <= data_ok ? IDLE : WAIT_DATA;
                end
                WAIT_DATA: begin
                    if (data_ok)        state <= IDLE;
                    else if (exp_flush) state <= DRAIN;
                end
                DRAIN: if (data_ok) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // next stage-1 contents: load/store completion, ALU result, or bubble
    always_comb begin
        s1_d   = '0;
        ld_res = ld_ext(cur_op.ls_type, cur_op.off, rdata);
        if (complete) begin
            s1_d.pc = cur_op.pc;
            s1_d.t  = t_dec(cur_op.t);
            if (cur_op.ls_type <= LS_LWR) begin
                s1_d.wreg_en = cur_op.wreg_en;
                s1_d.reg_id  = cur_op.reg_id;
                s1_d.be      = ld_res[35:32];
                s1_d.data    = ld_res[31:0];
            end
        end else if (e_valid && !mem_op && !exp_flush) begin
            s1_d.wreg_en = e_wreg_en;
            s1_d.reg_id  = e_reg_id;
            s1_d.be      = 4'hF;
            s1_d.data    = e_data;
            s1_d.pc      = e_pc;
            s1_d.t       = t_dec(e_t);
        end else if (mis && !exp_flush) begin
            s1_d.pc = e_pc;
        end
    end

    // result pipeline; flush empties every stage
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            for (int k = 1; k <= STAGES; k++) stg[k] <= '0;
        end else if (exp_flush) begin
            for (int k = 1; k <= STAGES; k++) stg[k] <= '0;
        end else begin
            stg[1] <= s1_d;
            for (int k = 2; k <= STAGES; k++) begin
                stg[k]   <= stg[k-1];
                stg[k].t <= t_dec(stg[k-1].t);
            end
        end
    end

    assign m_wreg_en = stg[STAGES].wreg_en;
    assign m_reg_be  = stg[STAGES].be;
    assign m_reg_id  = stg[STAGES].reg_id;
    assign m_data    = stg[STAGES].data;
    assign m_pc      = stg[STAGES].pc;
    assign m_t       = stg[STAGES].t;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed bench for mem_stage_pipe: STAGES=1 and STAGES=3 instances share stimulus.
module tb_mem_stage_pipe;

    logic        Clk = 1'b0;
    logic        Clr;
    logic        exp_flush, e_valid, e_mem, e_wreg_en, addr_ok, data_ok;
    logic [31:0] e_pc, e_data, e_rt_value, rdata;
    logic [3:0]  e_ls_type, e_t;
    logic [4:0]  e_rt_id, e_reg_id;

    logic        stall1, req1, wr1, mwe1, stall3, req3, wr3, mwe3;
    logic [1:0]  size1, size3;
    logic [31:0] addr1, wdata1, mdata1, mpc1, addr3, wdata3, mdata3, mpc3;
    logic [3:0]  wstrb1, mbe1, mt1, wstrb3, mbe3, mt3;
    logic [4:0]  mid1, mid3;
`ifdef MEM_ALIGN_EXC_EN
    logic        adel1, ades1, adel3, ades3;
    logic [31:0] bva1, bva3;
`endif

    int nvec = 0;
    int nmis = 0;

    always #5 Clk = ~Clk;

    mem_stage_pipe #(.STAGES(1), .T_W(4), .PC_W(32)) u_dut1 (
        .Clk(Clk), .Clr(Clr), .exp_flush(exp_flush), .e_valid(e_valid), .e_pc(e_pc),
        .e_data(e_data), .e_mem(e_mem), .e_ls_type(e_ls_type), .e_rt_id(e_rt_id),
        .e_rt_value(e_rt_value), .e_wreg_en(e_wreg_en), .e_reg_id(e_reg_id), .e_t(e_t),
        .stall(stall1), .req(req1), .wr(wr1), .size(size1), .addr(addr1), .wdata(wdata1),
        .wstrb(wstrb1), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .m_wreg_en(mwe1), .m_reg_be(mbe1), .m_reg_id(mid1), .m_data(mdata1),
        .m_pc(mpc1), .m_t(mt1)
`ifdef MEM_ALIGN_EXC_EN
        , .adel(adel1), .ades(ades1), .badvaddr(bva1)
`endif
    );

    mem_stage_pipe #(.STAGES(3), .T_W(4), .PC_W(32)) u_dut3 (
        .Clk(Clk), .Clr(Clr), .exp_flush(exp_flush), .e_valid(e_valid), .e_pc(e_pc),
        .e_data(e_data), .e_mem(e_mem), .e_ls_type(e_ls_type), .e_rt_id(e_rt_id),
        .e_rt_value(e_rt_value), .e_wreg_en(e_wreg_en), .e_reg_id(e_reg_id), .e_t(e_t),
        .stall(stall3), .req(req3), .wr(wr3), .size(size3), .addr(addr3), .wdata(wdata3),
        .wstrb(wstrb3), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .m_wreg_en(mwe3), .m_reg_be(mbe3), .m_reg_id(mid3), .m_data(mdata3),
        .m_pc(mpc3), .m_t(mt3)
`ifdef MEM_ALIGN_EXC_EN
        , .adel(adel3), .ades(ades3), .badvaddr(bva3)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        exp_flush = 0; e_valid = 0; e_mem = 0; e_wreg_en = 0;
        e_ls_type = 4'd15; e_rt_id = 0; e_rt_value = 0; e_reg_id = 0; e_t = 0;
        e_pc = 0; e_data = 0; addr_ok = 0; data_ok = 0; rdata = 0;
    endtask

    task automatic mem_op(input logic [3:0] ty, input logic [31:0] a, input logic [4:0] rd,
                          input logic [31:0] pc);
        e_valid = 1; e_mem = 1; e_ls_type = ty; e_data = a; e_reg_id = rd;
        e_wreg_en = (ty <= 4'd6); e_pc = pc;
    endtask

    initial begin
        idle();
        Clr = 1;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_mwe", {31'b0, mwe1}, 0);
        chk("rst_mdata", mdata1, 0);
        chk("rst_mdata3", mdata3, 0);
        chk("rst_req", {31'b0, req1}, 0);
        chk("rst_stall", {31'b0, stall1}, 0);
        Clr = 0;
        step();

        // LB at 0x1003, single-cycle handshake
        mem_op(4'd0, 32'h1003, 5'd3, 32'h400); e_t = 2;
        addr_ok = 1; data_ok = 1; rdata = 32'h80AA5511;
        #1;
        chk("lb_req", {31'b0, req1}, 1);
        chk("lb_addr", addr1, 32'h1003);
        chk("lb_size", {30'b0, size1}, 0);
        chk("lb_stall", {31'b0, stall1}, 0);
        step(); idle();
        chk("lb_mdata", mdata1, 32'hFFFFFF80);
        chk("lb_mbe", {28'b0, mbe1}, 32'hF);
        chk("lb_mid", {27'b0, mid1}, 3);
        chk("lb_mwe", {31'b0, mwe1}, 1);
        chk("lb_mt", {28'b0, mt1}, 1);
        chk("lb_mpc", mpc1, 32'h400);
        step();
        chk("lb_bubble", {31'b0, mwe1}, 0);
        step();
        chk("lb3_mdata", mdata3, 32'hFFFFFF80);
        chk("lb3_mt", {28'b0, mt3}, 0);

        // LW: addr_ok cycle 0, data_ok cycle 3
        mem_op(4'd4, 32'h2000, 5'd7, 32'h404); addr_ok = 1;
        #1;
        chk("lw_req_c0", {31'b0, req1}, 1);
        chk("lw_stall_c0", {31'b0, stall1}, 1);
        step(); addr_ok = 0; #1;
        chk("lw_req_c1", {31'b0, req1}, 0);
        chk("lw_stall_c1", {31'b0, stall1}, 1);
        chk("lw_bub_c1", {31'b0, mwe1}, 0);
        step(); #1;
        chk("lw_stall_c2", {31'b0, stall1}, 1);
        step(); data_ok = 1; rdata = 32'h12345678; #1;
        chk("lw_stall_c3", {31'b0, stall1}, 0);
        step(); idle();
        chk("lw_mdata", mdata1, 32'h12345678);
        chk("lw_mid", {27'b0, mid1}, 7);
        chk("lw_mwe", {31'b0, mwe1}, 1);

        // flush in WAIT_DATA, late data drained, next LW waits for it
        mem_op(4'd4, 32'h3000, 5'd9, 32'h408); addr_ok = 1;
        step(); idle(); exp_flush = 1;
        step(); exp_flush = 0;
        mem_op(4'd4, 32'h3004, 5'd10, 32'h40C); #1;
        chk("drn_req", {31'b0, req1}, 0);
        chk("drn_stall", {31'b0, stall1}, 1);
        chk("drn_mwe", {31'b0, mwe1}, 0);
        step(); data_ok = 1; rdata = 32'hDEADBEEF; #1;
        chk("drn_stall_dok", {31'b0, stall1}, 1);
        chk("drn_req_dok", {31'b0, req1}, 0);
        step();
        chk("drn_no_wb", {31'b0, mwe1}, 0);
        addr_ok = 1; data_ok = 1; rdata = 32'h0BADF00D; #1;
        chk("drn_req_after", {31'b0, req1}, 1);
        chk("drn_addr_after", addr1, 32'h3004);
        chk("drn_stall_after", {31'b0, stall1}, 0);
        step(); idle();
        chk("drn_mdata", mdata1, 32'h0BADF00D);
        chk("drn_mid", {27'b0, mid1}, 10);

        // ADDU r5 then SWR r5 off=2, forwarded from stage 1
        e_valid = 1; e_data = 32'hA1B2C3D4; e_wreg_en = 1; e_reg_id = 5; e_t = 5; #1;
        chk("addu_stall", {31'b0, stall3}, 0);
        chk("addu_req", {31'b0, req3}, 0);
        step(); idle();
        mem_op(4'd12, 32'h4002, 5'd0, 32'h414); e_rt_id = 5; e_rt_value = 32'h11111111;
        addr_ok = 1; data_ok = 1; #1;
        chk("swr_wdata3", wdata3, 32'hC3D40000);
        chk("swr_wstrb3", {28'b0, wstrb3}, 32'hC);
        chk("swr_addr3", addr3, 32'h4000);
        chk("swr_wr3", {31'b0, wr3}, 1);
        chk("swr_wdata1", wdata1, 32'hC3D40000);
        step(); idle();
        step();
        chk("addu3_mdata", mdata3, 32'hA1B2C3D4);
        chk("addu3_mid", {27'b0, mid3}, 5);
        chk("addu3_mt", {28'b0, mt3}, 2);
        step();
        chk("swr3_nowb", {31'b0, mwe3}, 0);

        // LWL / LWR at off=1
        mem_op(4'd5, 32'h5001, 5'd11, 32'h418); addr_ok = 1; data_ok = 1; rdata = 32'h44332211; #1;
        chk("lwl_addr", addr1, 32'h5000);
        chk("lwl_size", {30'b0, size1}, 2);
        step(); idle();
        chk("lwl_mdata", mdata1, 32'h22110000);
        chk("lwl_mbe", {28'b0, mbe1}, 32'hC);
        mem_op(4'd6, 32'h5001, 5'd12, 32'h41C); addr_ok = 1; data_ok = 1; rdata = 32'h44332211;
        step(); idle();
        chk("lwr_mdata", mdata1, 32'h00443322);
        chk("lwr_mbe", {28'b0, mbe1}, 32'h7);

        // SWL off=1 and SB off=3 lane placement
        mem_op(4'd11, 32'h6001, 5'd0, 32'h420); e_rt_value = 32'hAABBCCDD; addr_ok = 1; data_ok = 1; #1;
        chk("swl_wdata", wdata1, 32'h0000AABB);
        chk("swl_wstrb", {28'b0, wstrb1}, 32'h3);
        step();
        mem_op(4'd8, 32'h6003, 5'd0, 32'h424); e_rt_value = 32'hAABBCCDD; #1;
        chk("sb_wdata", wdata1, 32'hDD000000);
        chk("sb_wstrb", {28'b0, wstrb1}, 32'h8);
        chk("sb_addr", addr1, 32'h6003);
        step(); idle();

`ifdef MEM_ALIGN_EXC_EN
        mem_op(4'd4, 32'h1002, 5'd13, 32'h428); #1;
        chk("adel_req", {31'b0, req1}, 0);
        chk("adel_pulse", {31'b0, adel1}, 1);
        chk("adel_ades", {31'b0, ades1}, 0);
        chk("adel_bva", bva1, 32'h1002);
        chk("adel_stall", {31'b0, stall1}, 0);
        step(); idle(); #1;
        chk("adel_clear", {31'b0, adel1}, 0);
        chk("adel_nowb", {31'b0, mwe1}, 0);
        mem_op(4'd9, 32'h1001, 5'd0, 32'h42C); #1;
        chk("ades_pulse", {31'b0, ades1}, 1);
        chk("ades_req", {31'b0, req1}, 0);
        step(); idle();
`else
        mem_op(4'd4, 32'h1002, 5'd13, 32'h428); addr_ok = 1; data_ok = 1; rdata = 32'hCAFEF00D; #1;
        chk("lw_mask_addr", addr1, 32'h1000);
        step(); idle();
        chk("lw_mask_mdata", mdata1, 32'hCAFEF00D);
        mem_op(4'd2, 32'h1003, 5'd14, 32'h42C); addr_ok = 1; data_ok = 1; rdata = 32'h80010000; #1;
        chk("lh_mask_addr", addr1, 32'h1002);
        chk("lh_mask_size", {30'b0, size1}, 1);
        step(); idle();
        chk("lh_mask_mdata", mdata1, 32'hFFFF8001);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
